// File: rtl/echo_request_deserializer.sv
// Assembles one tag word plus its payload words into a 192-bit request message
// and holds it on the pipe_enq handshake until the dispatcher takes it.
module echo_request_deserializer #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                in_enq_ena,
  input  logic [WORD_W-1:0]   in_enq_v,
  output logic                in_enq_rdy,
  output logic                pipe_enq_ena,
  output logic [6*WORD_W-1:0] pipe_enq_v,
  input  logic                pipe_enq_rdy,
  output logic [CNT_W-1:0]    msg_count
);

  localparam int unsigned SLOTS  = 6;
  localparam int unsigned MSG_W  = SLOTS * WORD_W;
  localparam int unsigned BEAT_W = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_FULL
  } state_e;

  state_e              state_q, state_d;
  logic [MSG_W-1:0]    buf_q, buf_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [BEAT_W-1:0]   total_q, total_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                rdy_q, rdy_d;
  logic                ena_q, ena_d;

  logic                in_fire_c;
  logic                out_fire_c;
  logic [BEAT_W-1:0]   slot_c;
  logic [WORD_W-1:0]   tag_c;

  assign in_fire_c  = in_enq_ena & rdy_q;
  assign out_fire_c = ena_q & pipe_enq_rdy;
  assign tag_c      = buf_q[WORD_W-1:0];

  // Tag 2 payload lands in the say2 fields, two slots above the beat index
  always_comb begin
    slot_c = beat_q;
    if (tag_c == WORD_W'(2)) slot_c = BEAT_W'(beat_q + BEAT_W'(2));
  end

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    beat_d  = beat_q;
    total_d = total_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (in_fire_c) begin
          buf_d             = '0;
          buf_d[WORD_W-1:0] = in_enq_v;
          beat_d            = BEAT_W'(1);
          total_d           = ((in_enq_v == WORD_W'(1)) || (in_enq_v == WORD_W'(2)))
                              ? BEAT_W'(3) : BEAT_W'(6);
          state_d           = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (in_fire_c) begin
          for (int unsigned i = 1; i < SLOTS; i++) begin
            if (slot_c == BEAT_W'(i)) buf_d[i*WORD_W +: WORD_W] = in_enq_v;
          end
          beat_d = BEAT_W'(beat_q + BEAT_W'(1));
          if (BEAT_W'(beat_q + BEAT_W'(1)) == total_q) state_d = S_FULL;
        end
      end
      S_FULL: begin
        if (out_fire_c) begin
          state_d = S_IDLE;
          cnt_d   = CNT_W'(cnt_q + CNT_W'(1));
        end
      end
      default: state_d = S_IDLE;
    endcase
    rdy_d = (state_d != S_FULL);
    ena_d = (state_d == S_FULL);
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= S_IDLE;
      buf_q   <= '0;
      beat_q  <= '0;
      total_q <= '0;
      cnt_q   <= '0;
      rdy_q   <= 1'b1;
      ena_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      beat_q  <= beat_d;
      total_q <= total_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
      ena_q   <= ena_d;
    end
  end

  assign in_enq_rdy   = rdy_q;
  assign pipe_enq_ena = ena_q;
  assign pipe_enq_v   = buf_q;
  assign msg_count    = cnt_q;

endmodule

// File: tb/tb_echo_request_deserializer.sv
// Directed bench for echo_request_deserializer: message-level model plus
// hand-computed literal expectations; a narrow-counter twin exercises wrap.
module tb_echo_request_deserializer;

  logic         clk = 1'b0;
  logic         nrst = 1'b0;
  logic         in_ena = 1'b0;
  logic [31:0]  in_v = '0;
  logic         pipe_rdy = 1'b1;

  logic         in_rdy, ena;
  logic [191:0] v;
  logic [15:0]  cnt;
  logic         in_rdy_s, ena_s;
  logic [191:0] v_s;
  logic [5:0]   cnt_s;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  echo_request_deserializer u_dut (
    .CLK(clk), .nRST(nrst),
    .in_enq_ena(in_ena), .in_enq_v(in_v), .in_enq_rdy(in_rdy),
    .pipe_enq_ena(ena), .pipe_enq_v(v), .pipe_enq_rdy(pipe_rdy),
    .msg_count(cnt)
  );

  echo_request_deserializer #(.CNT_W(6)) u_dut_small (
    .CLK(clk), .nRST(nrst),
    .in_enq_ena(in_ena), .in_enq_v(in_v), .in_enq_rdy(in_rdy_s),
    .pipe_enq_ena(ena_s), .pipe_enq_v(v_s), .pipe_enq_rdy(pipe_rdy),
    .msg_count(cnt_s)
  );

  task automatic check(input string nm, input logic [191:0] act, input logic [191:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Message-level model: words of the message in flight, the held message, a count
  bit           m_full = 1'b0;
  logic [31:0]  m_words[$];
  logic [191:0] m_msg = '0;
  int unsigned  m_count = 0;
  int           m_need = 6;

  function automatic logic [191:0] build_msg();
    logic [191:0] m;
    m = '0;
    m[31:0] = m_words[0];
    if (m_words[0] == 32'd1) begin
      m[63:32] = m_words[1];
      m[95:64] = m_words[2];
    end else if (m_words[0] == 32'd2) begin
      m[127:96]  = m_words[1];
      m[159:128] = m_words[2];
    end else begin
      for (int k = 1; k < 6; k++) m[k*32 +: 32] = m_words[k];
    end
    return m;
  endfunction

  always @(posedge clk) begin
    if (!nrst) begin
      m_full = 1'b0;
      m_words.delete();
      m_count = 0;
    end else if (m_full) begin
      if (pipe_rdy) begin
        m_full = 1'b0;
        m_count++;
      end
    end else if (in_ena) begin
      m_words.push_back(in_v);
      if (m_words.size() == 1) m_need = ((in_v == 32'd1) || (in_v == 32'd2)) ? 3 : 6;
      else if (m_words.size() == m_need) begin
        m_msg  = build_msg();
        m_full = 1'b1;
        m_words.delete();
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  bit run = 1'b0;
  always @(negedge clk) begin
    if (run) begin
      logic [31:0] mc;
      mc = m_count;
      check("in_rdy", 192'(in_rdy), 192'(!m_full));
      check("pipe_ena", 192'(ena), 192'(m_full));
      check("msg_count", 192'(cnt), 192'(mc[15:0]));
      check("in_rdy_small", 192'(in_rdy_s), 192'(!m_full));
      check("pipe_ena_small", 192'(ena_s), 192'(m_full));
      check("msg_count_small", 192'(cnt_s), 192'(mc[5:0]));
      if (m_full) begin
        check("pipe_v", v, m_msg);
        check("pipe_v_small", v_s, m_msg);
      end
    end
  end

  task automatic send(input logic [31:0] w, input int gap);
    int n;
    repeat (gap) begin
      @(negedge clk);
      in_ena = 1'b0;
    end
    @(negedge clk);
    in_ena = 1'b1;
    in_v   = w;
    n = 0;
    while (in_rdy !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_bad++;
      $display("FAIL send_timeout at %0t: word %h never accepted", $time, w);
    end
    @(posedge clk);
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_rdy"}, 192'(in_rdy), 192'(1));
    check({nm, "_ena"}, 192'(ena), 192'(0));
    check({nm, "_v"}, v, 192'(0));
    check({nm, "_cnt"}, 192'(cnt), 192'(0));
  endtask

  initial begin
    run = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    nrst = 1'b1;

    // Tag 1 back-to-back
    send(32'd1, 0); send(32'h11, 0); send(32'h22, 0);
    @(negedge clk); in_ena = 1'b0;
    check("t1_ena", 192'(ena), 192'(1));
    check("t1_v", v, {32'h0, 32'h0, 32'h0, 32'h22, 32'h11, 32'h1});
    @(negedge clk);
    check("t1_cnt", 192'(cnt), 192'(1));

    // Tag 2 after tag 1: say fields must read zero
    send(32'd2, 0); send(32'hA, 0); send(32'hB, 0);
    @(negedge clk); in_ena = 1'b0;
    check("t2_v", v, {32'h0, 32'hB, 32'hA, 32'h0, 32'h0, 32'h2});
    @(negedge clk);
    check("t2_cnt", 192'(cnt), 192'(2));

    // Unknown tag 7 with idle gaps between words
    send(32'd7, 0);
    for (int k = 1; k <= 4; k++) send(32'(k), 2);
    @(negedge clk); in_ena = 1'b0;
    check("t7_not_full", 192'(ena), 192'(0));
    send(32'd5, 1);
    @(negedge clk); in_ena = 1'b0;
    check("t7_v", v, {32'h0, 32'h5, 32'h4, 32'h3, 32'h2, 32'h1} << 32 | 192'h7);
    @(negedge clk);
    check("t7_cnt", 192'(cnt), 192'(3));

    // Backpressure for 10 cycles with a word offered the whole time
    pipe_rdy = 1'b0;
    send(32'd1, 0); send(32'h33, 0); send(32'h44, 0);
    @(negedge clk); in_v = 32'd1;
    repeat (10) @(negedge clk);
    check("bp_v", v, {32'h0, 32'h0, 32'h0, 32'h44, 32'h33, 32'h1});
    check("bp_in_rdy", 192'(in_rdy), 192'(0));
    pipe_rdy = 1'b1;
    @(negedge clk);
    check("bp_cnt", 192'(cnt), 192'(4));
    @(posedge clk);
    send(32'h55, 0); send(32'h66, 0);
    @(negedge clk); in_ena = 1'b0;
    check("bp_next_v", v, {32'h0, 32'h0, 32'h0, 32'h66, 32'h55, 32'h1});
    @(negedge clk);
    check("bp_next_cnt", 192'(cnt), 192'(5));

    // Reset after tag and one payload word
    send(32'd1, 0); send(32'h77, 0);
    @(negedge clk); in_ena = 1'b0; nrst = 1'b0;
    @(negedge clk); nrst = 1'b1;
    check_reset_outputs("midrst");
    send(32'd1, 0); send(32'h88, 0); send(32'h99, 0);
    @(negedge clk); in_ena = 1'b0;
    check("midrst_v", v, {32'h0, 32'h0, 32'h0, 32'h99, 32'h88, 32'h1});
    @(negedge clk);
    check("midrst_cnt", 192'(cnt), 192'(1));

    // Back-to-back stream; the 6-bit twin wraps past 63
    for (int i = 0; i < 70; i++) begin
      send(32'd1, 0); send(32'(i), 0); send(32'(i + 100), 0);
    end
    @(negedge clk); in_ena = 1'b0;
    @(negedge clk);
    check("wrap_cnt", 192'(cnt), 192'(71));
    check("wrap_cnt_small", 192'(cnt_s), 192'(7));

    repeat (2) @(negedge clk);
    run = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
